l1_cache_ctrl: RTL and testbench
================================

Name: l1_cache_ctrl

Overview:
Control FSM for the 32 KB, 4-way, 32 B-line L1 cache. It accepts one CPU word request at a time. It owns the tag/valid/dirty arrays and the per-set pseudo-LRU state, and sequences an external data array. On a miss it performs a dirty-victim writeback, then a line fill from next-level memory.

Parameters:
ADDR_WIDTH, 32, from cache_pkg
DATA_WIDTH, 32, from cache_pkg
WAYS, L1_WAYS (4), associativity; must be 4 (3-bit tree PLRU)
SETS, L1_SETS (256), sets per way
LINE_BITS, L1_DATABITS (256), line width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  CPU request valid
req_ready  out  1  high only in IDLE
req_we  in  1  1=write, 0=read
req_addr  in  32  byte address; [1:0] ignored
req_wdata  in  32  write word
req_be  in  4  write byte enables
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  read word; 0 for writes
da_en  out  1  data array access
da_we  out  1  data array write
da_way  out  2  way select
da_index  out  8  set index
da_wmask  out  32  byte write mask
da_wline  out  256  write line
da_rline  in  256  read line, valid the cycle after a da_en read
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accept
mem_req_we  out  1  1=writeback, 0=fill
mem_req_addr  out  32  line-aligned address ([4:0]=0)
mem_req_wdata  out  256  writeback line
mem_resp_valid  in  1  fill data valid
mem_resp_rdata  in  256  fill line

Behaviour:
- Address split: tag=[31:13] (L1_TAG=19), index=[12:5], word=[4:2].
- Reset: all outputs 0, FSM=IDLE, all valid/dirty=0, all PLRU=3'b000. Tags are not reset.
- FSM states: IDLE, LOOKUP, RESP, WB_READ, WB_REQ, FILL_REQ, FILL_WAIT, FILL_WRITE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request and go to LOOKUP.
- LOOKUP: compare all 4 ways.
  - Hit: drive da_en to the hit way.
    - Read: da_we=0.
    - Write: da_we=1, da_wline = word replicated 8×, da_wmask = req_be shifted to byte lane word*4; set dirty.
    - Update PLRU, go to RESP.
  - Miss: victim = lowest invalid way, else PLRU victim.
    - Victim valid and dirty → WB_READ.
    - Otherwise → FILL_REQ.
- RESP:
  - resp_valid=1 for one cycle.
  - resp_rdata = da_rline word [word*32 +: 32] for reads, 0 for writes.
  - Go to IDLE.
  - Hit latency: resp_valid 2 cycles after the accept edge.
- WB_READ: da_en read of the victim way; capture da_rline next cycle, go to WB_REQ.
- WB_REQ:
  - mem_req_valid=1, we=1, addr={victim_tag,index,5'b0}, wdata=captured line.
  - All outputs held stable until mem_req_ready; the write is complete at the handshake.
  - Then go to FILL_REQ.
- FILL_REQ: mem_req_valid=1, we=0, addr={req_tag,index,5'b0}, held until mem_req_ready → FILL_WAIT.
- FILL_WAIT: wait for mem_resp_valid, capture mem_resp_rdata.
  - mem_resp_valid in any other state is ignored.
- FILL_WRITE:
  - Write the line to the victim way with da_wmask all-ones.
  - Set tag=req_tag, valid=1, dirty=0.
  - Go to LOOKUP; the replay hits, so a write miss merges through the normal hit path.
- PLRU (b0,b1,b2):
  - Access way w: b0=~w[1]; if w[1]=0 then b1=~w[0], else b2=~w[0].
  - Victim: b0=0 → {0,b1}; b0=1 → {1,b2}.
- One request outstanding; no hit-under-miss.
- mem_req_valid is never dropped before mem_req_ready.
- rst asserted mid-operation:
  - Immediate return to IDLE, caches invalidated, outstanding memory transaction abandoned.
  - The memory side shares rst.

Decomposition:
- cache_pkg: L1_TAG/L1_INDEX/L1_OFFSET are the width source.
- Add to cache_pkg:
  - state enum typedef l1_state_e;
  - packed address struct l1_addr_t {tag,index,offset};
  - l1_plru_t (3 bits).
- Sub-module l1_plru: pure-combinational update/victim function pair; state storage stays in the controller.

Test Plan:
- Reset, then read 0x0000_1000 (cold miss, way0 clean) → one fill request at 0x0000_1000 with we=0; fill line word0=0xDEADBEEF → resp_rdata=0xDEADBEEF; no writeback.
- Repeat read 0x0000_1000 → no mem_req_valid; resp_valid exactly 2 cycles after the accept edge.
- Write 0x0000_1004 data 0x12345678 be=4'b0011 (hit) → da_wmask=32'h0000_0030; subsequent read returns {old[31:16],16'h5678}.
- Fill 4 ways of index 0 (tags 0..3 at 0x0000_0000, 0x0000_2000, 0x0000_4000, 0x0000_6000), touch way0, make it dirty, read 0x0000_8000 → victim way2 (PLRU b0=1,b2=0); no writeback since way2 clean.
- Dirty victim with mem_req_ready held low 5 cycles → writeback request stable all 5 cycles, writeback precedes fill, writeback addr equals old line address.
- Assert rst during FILL_WAIT → mem_req_valid=0, req_ready=1 after release; previous hit address now misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and address/PLRU types for the L1 cache controller.
// Latency: none (declarations only).
// Backpressure: n/a.
package cache_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int L1_WAYS     = 4;
    localparam int L1_SETS     = 256;
    localparam int L1_DATABITS = 256;
    localparam int L1_TAG      = 19;
    localparam int L1_INDEX    = 8;
    localparam int L1_OFFSET   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RESP,
        ST_WB_READ,
        ST_WB_REQ,
        ST_FILL_REQ,
        ST_FILL_WAIT,
        ST_FILL_WRITE
    } l1_state_e;

    typedef struct packed {
        logic [L1_TAG-1:0]    tag;
        logic [L1_INDEX-1:0]  index;
        logic [L1_OFFSET-1:0] offset;
    } l1_addr_t;

    // Tree PLRU bits: [0] root (which half), [1] ways 0/1, [2] ways 2/3.
    typedef logic [2:0] l1_plru_t;

endpackage

// File: rtl/l1_cache_ctrl_plru.sv
// 4-way tree pseudo-LRU: next state after touching a way, and the current victim.
// Latency: purely combinational.
// Backpressure: none; the controller owns the per-set state registers.
module l1_plru
    import cache_pkg::*;
(
    input  l1_plru_t   i_plru,
    input  logic [1:0] i_way,
    output l1_plru_t   o_plru_upd,
    output logic [1:0] o_victim
);

    // Point every tree node on the path away from the accessed way; victim follows the pointers.
    always_comb begin
        o_plru_upd    = i_plru;
        o_plru_upd[0] = ~i_way[1];
        if (!i_way[1]) begin
            o_plru_upd[1] = ~i_way[0];
        end else begin
            o_plru_upd[2] = ~i_way[0];
        end
        o_victim = i_plru[0] ? {1'b1, i_plru[2]} : {1'b0, i_plru[1]};
    end

endmodule

// File: rtl/l1_cache_ctrl.sv
// L1 cache control FSM: tag/valid/dirty/PLRU owner, data-array sequencer, writeback + fill on miss.
// Latency: hit responds 2 cycles after accept; miss adds optional writeback, fill and a replay lookup.
// Backpressure: one request at a time (req_ready only in IDLE); memory requests held until mem_req_ready.
module l1_cache_ctrl
    import cache_pkg::*;
#(
    parameter int WAYS      = L1_WAYS,
    parameter int SETS      = L1_SETS,
    parameter int LINE_BITS = L1_DATABITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_be,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  da_en,
    output logic                  da_we,
    output logic [1:0]            da_way,
    output logic [L1_INDEX-1:0]   da_index,
    output logic [31:0]           da_wmask,
    output logic [LINE_BITS-1:0]  da_wline,
    input  logic [LINE_BITS-1:0]  da_rline,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_BITS-1:0]  mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [LINE_BITS-1:0]  mem_resp_rdata
);

    l1_state_e r_state;
    l1_state_e w_next;

    logic                  r_we;
    l1_addr_t              r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_be;
    logic [1:0]            r_victim;
    logic [LINE_BITS-1:0]  r_line;
    logic                  r_rd_phase;

    logic [SETS-1:0]       r_valid [WAYS];
    logic [SETS-1:0]       r_dirty [WAYS];
    logic [L1_TAG-1:0]     r_tag   [WAYS][SETS];
    l1_plru_t              r_plru  [SETS];

    logic [L1_INDEX-1:0]   w_idx;
    logic [2:0]            w_word;
    logic [WAYS-1:0]       w_hit_vec;
    logic                  w_hit;
    logic [1:0]            w_hit_way;
    logic                  w_any_inv;
    logic [1:0]            w_inv_way;
    l1_plru_t              w_plru_upd;
    logic [1:0]            w_plru_victim;
    logic [1:0]            w_victim;
    logic                  w_victim_dirty;
    logic                  w_unused;

    assign w_idx    = r_addr.index;
    assign w_word   = r_addr.offset[4:2];
    assign w_unused = ^r_addr.offset[1:0];

    l1_plru u_plru (
        .i_plru     (r_plru[w_idx]),
        .i_way      (w_hit_way),
        .o_plru_upd (w_plru_upd),
        .o_victim   (w_plru_victim)
    );

    // Per-way tag compare for the latched set.
    always_comb begin
        w_hit_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == r_addr.tag);
        end
    end

    // Encode hit way and lowest invalid way (descending scan so the lowest wins).
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_any_inv = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) begin
                w_hit     = 1'b1;
                w_hit_way = 2'(w);
            end
            if (!r_valid[w][w_idx]) begin
                w_any_inv = 1'b1;
                w_inv_way = 2'(w);
            end
        end
    end

    assign w_victim       = w_any_inv ? w_inv_way : w_plru_victim;
    assign w_victim_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and all outputs, decoded from the current state.
    always_comb begin
        w_next        = r_state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        da_en         = 1'b0;
        da_we         = 1'b0;
        da_way        = '0;
        da_index      = '0;
        da_wmask      = '0;
        da_wline      = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                // Held low while reset is asserted so every output reads 0 in reset.
                req_ready = ~rst;
                if (req_valid) begin
                    w_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    da_en    = 1'b1;
                    da_way   = w_hit_way;
                    da_index = w_idx;
                    if (r_we) begin
                        da_we    = 1'b1;
                        da_wline = {8{r_wdata}};
                        da_wmask = {28'd0, r_be} << {w_word, 2'b00};
                    end
                    w_next = ST_RESP;
                end else begin
                    w_next = w_victim_dirty ? ST_WB_READ : ST_FILL_REQ;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (!r_we) begin
                    resp_rdata = da_rline[{w_word, 5'b00000} +: DATA_WIDTH];
                end
                w_next = ST_IDLE;
            end
            ST_WB_READ: begin
                // Phase 0 issues the read, phase 1 is the cycle the line is returned.
                if (!r_rd_phase) begin
                    da_en    = 1'b1;
                    da_way   = r_victim;
                    da_index = w_idx;
                end else begin
                    w_next = ST_WB_REQ;
                end
            end
            ST_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {r_tag[r_victim][w_idx], w_idx, 5'b00000};
                mem_req_wdata = r_line;
                if (mem_req_ready) begin
                    w_next = ST_FILL_REQ;
                end
            end
            ST_FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {r_addr.tag, w_idx, 5'b00000};
                if (mem_req_ready) begin
                    w_next = ST_FILL_WAIT;
                end
            end
            ST_FILL_WAIT: begin
                if (mem_resp_valid) begin
                    w_next = ST_FILL_WRITE;
                end
            end
            ST_FILL_WRITE: begin
                da_en    = 1'b1;
                da_we    = 1'b1;
                da_way   = r_victim;
                da_index = w_idx;
                da_wmask = '1;
                da_wline = r_line;
                w_next   = ST_LOOKUP;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request latch, victim choice, and the line buffer shared by writeback and fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_victim   <= '0;
            r_line     <= '0;
            r_rd_phase <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && req_valid) begin
                r_we    <= req_we;
                r_addr  <= l1_addr_t'(req_addr);
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
            if (r_state == ST_LOOKUP && !w_hit) begin
                r_victim <= w_victim;
            end
            if (r_state == ST_WB_READ) begin
                r_rd_phase <= ~r_rd_phase;
                if (r_rd_phase) begin
                    r_line <= da_rline;
                end
            end
            if (r_state == ST_FILL_WAIT && mem_resp_valid) begin
                r_line <= mem_resp_rdata;
            end
        end
    end

    // Valid/dirty/PLRU bookkeeping; reset invalidates the whole cache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                r_plru[s] <= '0;
            end
        end else begin
            if (r_state == ST_LOOKUP && w_hit) begin
                r_plru[w_idx] <= w_plru_upd;
                if (r_we) begin
                    r_dirty[w_hit_way][w_idx] <= 1'b1;
                end
            end
            if (r_state == ST_FILL_WRITE) begin
                r_valid[r_victim][w_idx] <= 1'b1;
                r_dirty[r_victim][w_idx] <= 1'b0;
            end
        end
    end

    // Tag array: no reset, entries are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (r_state == ST_FILL_WRITE) begin
            r_tag[r_victim][w_idx] <= r_addr.tag;
        end
    end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Scoreboard bench for l1_cache_ctrl with behavioural data array and next-level memory.
// Latency: checks hit responses land 2 cycles after the accept edge.
// Backpressure: memory accept can be stalled for a programmable number of cycles.
module tb_l1_cache_ctrl;
    import cache_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [31:0]   req_addr, req_wdata;
    logic [3:0]    req_be;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          da_en, da_we;
    logic [1:0]    da_way;
    logic [7:0]    da_index;
    logic [31:0]   da_wmask;
    logic [255:0]  da_wline, da_rline;
    logic          mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0]   mem_req_addr;
    logic [255:0]  mem_req_wdata;
    logic          mem_resp_valid;
    logic [255:0]  mem_resp_rdata;

    l1_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .da_en(da_en), .da_we(da_we), .da_way(da_way), .da_index(da_index),
        .da_wmask(da_wmask), .da_wline(da_wline), .da_rline(da_rline),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } rexp_t;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } mexp_t;

    rexp_t       q_resp[$];
    mexp_t       q_mem[$];
    logic [31:0] q_wmask[$];

    int          stall   = 0;
    bit          no_resp = 1'b0;
    int          pend    = 0;
    logic [31:0] pend_addr = '0;

    logic [255:0] da_mem [4][256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_line(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Next-level memory content: word i of line a = {a[15:0], A5, i}; line 0x1000 word0 = DEADBEEF.
    function automatic logic [255:0] fill_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = {a[15:0], 8'hA5, 8'(i)};
        if (a == 32'h0000_1000) l[31:0] = 32'hDEAD_BEEF;
        return l;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural data array: one-cycle read latency, byte-masked writes.
    initial begin
        logic [255:0] tmp;
        da_rline = '0;
        for (int w = 0; w < 4; w++)
            for (int s = 0; s < 256; s++) da_mem[w][s] = '0;
        forever begin
            @(posedge clk);
            if (da_en) begin
                if (da_we) begin
                    tmp = da_mem[da_way][da_index];
                    for (int b = 0; b < 32; b++)
                        if (da_wmask[b]) tmp[b*8 +: 8] = da_wline[b*8 +: 8];
                    da_mem[da_way][da_index] = tmp;
                end else begin
                    da_rline <= da_mem[da_way][da_index];
                end
            end
        end
    end

    // Memory responder plus monitor: compares every output event against the queue heads.
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (rst) begin
                pend = 0;
                mem_req_ready = 1'b0;
                continue;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = fill_line(pend_addr);
                end
            end
            if (mem_req_valid && stall > 0) begin
                mem_req_ready = 1'b0;
                stall--;
            end else begin
                mem_req_ready = 1'b1;
            end
            if (mem_req_valid) begin
                if (q_mem.size() == 0) begin
                    fail_now("unexpected mem request");
                end else begin
                    chk("mem_req_we", 32'(mem_req_we), 32'(q_mem[0].we));
                    chk("mem_req_addr", mem_req_addr, q_mem[0].addr);
                    if (q_mem[0].we) chk_line("wb data", mem_req_wdata, q_mem[0].wdata);
                    if (mem_req_ready) void'(q_mem.pop_front());
                end
                if (mem_req_ready && !mem_req_we && !no_resp) begin
                    pend = 3;
                    pend_addr = mem_req_addr;
                end
            end
            if (resp_valid) begin
                if (q_resp.size() == 0) begin
                    fail_now("unexpected resp_valid");
                end else begin
                    chk("resp_rdata", resp_rdata, q_resp[0].rdata);
                    if (q_resp[0].lat >= 0)
                        chk("hit latency", 32'(cyc + 1 - q_resp[0].acc), 32'(q_resp[0].lat));
                    void'(q_resp.pop_front());
                end
            end
            if (da_en && da_we && da_wmask != 32'hFFFF_FFFF) begin
                if (q_wmask.size() == 0) fail_now("unexpected partial write");
                else chk("da_wmask", da_wmask, q_wmask.pop_front());
            end
        end
    end

    task automatic wait_drain();
        int t = 0;
        while ((q_resp.size() != 0 || q_mem.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q_resp.size() != 0 || q_mem.size() != 0) begin
            fail_now("transaction timeout");
            q_resp.delete();
            q_mem.delete();
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input bit chk_resp, input logic [31:0] exp_rdata,
                          input int lat);
        int t = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) fail_now("accept timeout");
        else if (chk_resp) q_resp.push_back('{exp_rdata, lat, cyc + 1});
        @(negedge clk);
        req_valid = 1'b0;
        if (chk_resp) wait_drain();
    endtask

    task automatic exp_fill(input logic [31:0] addr);
        q_mem.push_back('{1'b0, addr, 256'd0});
    endtask

    initial begin
        logic [255:0] wb_line;
        int t;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset da_en", 32'(da_en), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle req_ready", 32'(req_ready), 32'd1);

        // Cold read miss, then hits, then a partial write hit and its read-back.
        exp_fill(32'h0000_1000);
        do_req(1'b0, 32'h0000_1000, '0, '0, 1'b1, 32'hDEAD_BEEF, -1);
        do_req(1'b0, 32'h0000_1000, '0, '0, 1'b1, 32'hDEAD_BEEF, 2);
        q_wmask.push_back(32'h0000_0030);
        do_req(1'b1, 32'h0000_1004, 32'h1234_5678, 4'b0011, 1'b1, 32'h0, 2);
        do_req(1'b0, 32'h0000_1004, '0, '0, 1'b1, 32'h1000_5678, 2);

        // Fill all four ways of set 0.
        exp_fill(32'h0000_0000);
        do_req(1'b0, 32'h0000_0000, '0, '0, 1'b1, 32'h0000_A500, -1);
        exp_fill(32'h0000_2000);
        do_req(1'b0, 32'h0000_2000, '0, '0, 1'b1, 32'h2000_A500, -1);
        exp_fill(32'h0000_4000);
        do_req(1'b0, 32'h0000_4000, '0, '0, 1'b1, 32'h4000_A500, -1);
        exp_fill(32'h0000_6000);
        do_req(1'b0, 32'h0000_6000, '0, '0, 1'b1, 32'h6000_A500, -1);
        // Touch and dirty way0; PLRU now picks way2, which is clean.
        do_req(1'b0, 32'h0000_0000, '0, '0, 1'b1, 32'h0000_A500, 2);
        q_wmask.push_back(32'h0000_000F);
        do_req(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 1'b1, 32'h0, 2);
        exp_fill(32'h0000_8000);
        do_req(1'b0, 32'h0000_8000, '0, '0, 1'b1, 32'h8000_A500, -1);
        // 0x4000 was evicted; it refills into way1 (clean).
        exp_fill(32'h0000_4000);
        do_req(1'b0, 32'h0000_4000, '0, '0, 1'b1, 32'h4000_A500, -1);
        // Touch way3 so the PLRU victim becomes dirty way0.
        do_req(1'b0, 32'h0000_6000, '0, '0, 1'b1, 32'h6000_A500, 2);

        // Dirty victim with a 5-cycle stalled writeback, then the fill.
        wb_line = fill_line(32'h0000_0000);
        wb_line[31:0] = 32'hCAFE_F00D;
        q_mem.push_back('{1'b1, 32'h0000_0000, wb_line});
        exp_fill(32'h0000_A000);
        stall = 5;
        do_req(1'b0, 32'h0000_A000, '0, '0, 1'b1, 32'hA000_A500, -1);

        // Reset while waiting for fill data.
        no_resp = 1'b1;
        exp_fill(32'h0000_3000);
        do_req(1'b0, 32'h0000_3000, '0, '0, 1'b0, 32'h0, -1);
        t = 0;
        while (q_mem.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q_mem.size() != 0) begin
            fail_now("fill request before reset");
            q_mem.delete();
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid-reset mem_req_valid", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        no_resp = 1'b0;
        @(negedge clk);
        chk("post-reset req_ready", 32'(req_ready), 32'd1);
        chk("post-reset mem_req_valid", 32'(mem_req_valid), 32'd0);
        // Former hit address must now miss and refill.
        exp_fill(32'h0000_1000);
        do_req(1'b0, 32'h0000_1000, '0, '0, 1'b1, 32'hDEAD_BEEF, -1);

        repeat (5) @(negedge clk);
        chk("resp queue empty", 32'(q_resp.size()), 32'd0);
        chk("mem queue empty", 32'(q_mem.size()), 32'd0);
        chk("wmask queue empty", 32'(q_wmask.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
